// File: rtl/moving_sum_mem.sv
// rtl/moving_sum_mem.sv - recursive running-window sum and rounded average
// Two stages: accumulator update on en, then registered sum/avg one cycle later.
module moving_sum_mem #(
  parameter int DW        = 8,
  parameter int LEN       = 32,
  parameter int AVG_SHIFT = $clog2(LEN),
  localparam int SW       = DW + $clog2(LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic signed [DW-1:0]           din,
  input  logic signed [DW-1:0]           din_dly,
  output logic signed [SW-1:0]           sum,
  output logic signed [SW-AVG_SHIFT-1:0] avg,
  output logic                           out_en,
  output logic                           valid
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LEN);
  localparam int RS = (AVG_SHIFT > 0) ? AVG_SHIFT - 1 : 0;
  localparam logic signed [SW:0] RND = (AVG_SHIFT > 0) ? ((SW + 1)'(1) << RS) : '0;

  logic signed [SW-1:0]           acc_q, acc_d;
  logic        [CW-1:0]           fill_cnt_q, fill_cnt_d;
  logic                           en_d1_q;
  logic signed [SW-1:0]           sum_q;
  logic signed [SW-AVG_SHIFT-1:0] avg_q, avg_d;
  logic                           out_en_q;
  logic                           valid_q;
  logic                           full;
  logic signed [SW-1:0]           sub;
  logic signed [SW:0]             rnd_sum;

  // The delay-chain RAM is unreset, so its output is ignored until the window is full.
  always_comb begin
    full       = (fill_cnt_q == FULL_CNT);
    sub        = full ? SW'(din_dly) : '0;
    acc_d      = acc_q + SW'(din) - sub;
    fill_cnt_d = full ? fill_cnt_q : fill_cnt_q + CW'(1);
    rnd_sum    = {acc_q[SW-1], acc_q};
    rnd_sum    = rnd_sum + RND;
    avg_d      = (SW - AVG_SHIFT)'(rnd_sum >>> AVG_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      fill_cnt_q <= '0;
      en_d1_q    <= 1'b0;
      sum_q      <= '0;
      avg_q      <= '0;
      out_en_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      en_d1_q  <= en;
      out_en_q <= en_d1_q;
      if (en) begin
        acc_q      <= acc_d;
        fill_cnt_q <= fill_cnt_d;
      end
      // fill_cnt already reflects the sample now in acc, so full marks the LEN-th result.
      if (en_d1_q) begin
        sum_q <= acc_q;
        avg_q <= avg_d;
        if (full) valid_q <= 1'b1;
      end
    end
  end

  assign sum    = sum_q;
  assign avg    = avg_q;
  assign out_en = out_en_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_moving_sum_mem.sv
// tb/tb_moving_sum_mem.sv - randomized and directed checks of moving_sum_mem
// Reference: software window over strobe history, delay chain modelled with zero latency.
module tb_moving_sum_mem;
  localparam int LEN = 4;

  logic clk = 1'b0;
  logic rst, en;
  logic signed [7:0] din, din_dly;
  logic signed [9:0] sum;
  logic signed [7:0] avg;
  logic out_en, valid;

  int n_cmp = 0;
  int n_bad = 0;

  int hist[$];
  bit pend_en, pend_valid;
  int pend_sum;
  bit exp_out_en, exp_valid;
  int exp_sum, exp_avg;
  bit junk_random;

  moving_sum_mem #(.DW(8), .LEN(LEN), .AVG_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_dly(din_dly),
    .sum(sum), .avg(avg), .out_en(out_en), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic int avg_of(input int s);
    return $rtoi($floor((s + 2.0) / 4.0));
  endfunction

  task automatic clear_model();
    hist.delete();
    pend_en = 0; pend_valid = 0; pend_sum = 0;
    exp_out_en = 0; exp_valid = 0; exp_sum = 0; exp_avg = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  // Drive one cycle and advance the reference model; outputs sampled 1 time unit after the edge.
  task automatic drive(input bit e, input int d);
    int s, n;
    @(negedge clk);
    en = e;
    din = 8'(d);
    if (hist.size() >= LEN) din_dly = 8'(hist[hist.size() - LEN]);
    else din_dly = junk_random ? 8'($urandom) : 8'h55;
    @(posedge clk);
    exp_out_en = pend_en;
    if (pend_en) begin
      exp_sum = pend_sum; exp_avg = avg_of(pend_sum); exp_valid = pend_valid;
    end
    pend_en = e;
    if (e) begin
      hist.push_back(d);
      n = hist.size();
      s = 0;
      for (int i = (n > LEN ? n - LEN : 0); i < n; i++) s += hist[i];
      pend_sum = s;
      pend_valid = (n >= LEN);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; din = '0; din_dly = '0;
    do_reset();
    n_cmp++;
    if (sum !== 10'sd0 || avg !== 8'sd0 || out_en !== 1'b0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset sum/avg/out_en/valid got %0d/%0d/%0b/%0b want 0/0/0/0",
               sum, avg, out_en, valid);
    end
  endtask

  task automatic test_fill();
    int tbl_sum[6] = '{10, 20, 30, 40, 40, 40};
    int tbl_avg[6] = '{3, 5, 8, 10, 10, 10};
    int k = 0;
    junk_random = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(c < 6, 10);
      if (out_en) begin
        if (k >= 6) begin
          n_cmp++; n_bad++;
          $display("FAIL fill extra out_en got %0d want 6 updates", k + 1);
        end else begin
          n_cmp++;
          if (sum !== 10'(tbl_sum[k]) || avg !== 8'(tbl_avg[k]) || valid !== (k >= 3)) begin
            n_bad++;
            $display("FAIL fill step %0d sum/avg/valid got %0d/%0d/%0b want %0d/%0d/%0b",
                     k, sum, avg, valid, tbl_sum[k], tbl_avg[k], k >= 3);
          end
        end
        k++;
      end
    end
    n_cmp++;
    if (k !== 6) begin
      n_bad++;
      $display("FAIL fill update count got %0d want 6", k);
    end
  endtask

  task automatic test_ramp();
    junk_random = 1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(c < 6, c + 1);
      n_cmp++;
      if (out_en !== exp_out_en || sum !== 10'(exp_sum) || avg !== 8'(exp_avg) || valid !== exp_valid) begin
        n_bad++;
        $display("FAIL ramp cyc %0d out_en/sum/avg/valid got %0b/%0d/%0d/%0b want %0b/%0d/%0d/%0b",
                 c, out_en, sum, avg, valid, exp_out_en, exp_sum, exp_avg, exp_valid);
      end
    end
    n_cmp++;
    if (sum !== 10'sd18 || avg !== 8'sd5) begin
      n_bad++;
      $display("FAIL ramp final sum/avg got %0d/%0d want 18/5", sum, avg);
    end
  endtask

  task automatic test_min();
    junk_random = 1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(c < 8, -128);
      n_cmp++;
      if (out_en !== exp_out_en || sum !== 10'(exp_sum) || avg !== 8'(exp_avg) || valid !== exp_valid) begin
        n_bad++;
        $display("FAIL min cyc %0d out_en/sum/avg/valid got %0b/%0d/%0d/%0b want %0b/%0d/%0d/%0b",
                 c, out_en, sum, avg, valid, exp_out_en, exp_sum, exp_avg, exp_valid);
      end
    end
    n_cmp++;
    if (sum !== -10'sd512 || avg !== -8'sd128 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL min final sum/avg/valid got %0d/%0d/%0b want -512/-128/1", sum, avg, valid);
    end
  endtask

  task automatic test_gaps();
    bit pat[9] = '{1, 0, 0, 1, 0, 1, 1, 0, 0};
    junk_random = 1;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(pat[c], 7);
      n_cmp++;
      if (out_en !== exp_out_en || sum !== 10'(exp_sum) || avg !== 8'(exp_avg) || valid !== exp_valid) begin
        n_bad++;
        $display("FAIL gaps cyc %0d out_en/sum/avg/valid got %0b/%0d/%0d/%0b want %0b/%0d/%0d/%0b",
                 c, out_en, sum, avg, valid, exp_out_en, exp_sum, exp_avg, exp_valid);
      end
    end
    n_cmp++;
    if (sum !== 10'sd28 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL gaps final sum/valid got %0d/%0b want 28/1", sum, valid);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    junk_random = 0;
    do_reset();
    for (int c = 0; c < 6; c++) drive(1, 10);
    do_reset();
    n_cmp++;
    if (sum !== 10'sd0 || avg !== 8'sd0 || out_en !== 1'b0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst sum/avg/out_en/valid got %0d/%0d/%0b/%0b want 0/0/0/0",
               sum, avg, out_en, valid);
    end
    for (int c = 0; c < 7; c++) begin
      drive(c < 5, 10);
      if (out_en) begin
        k++;
        n_cmp++;
        if (sum !== 10'((k < 4 ? k : 4) * 10) || valid !== (k >= 4)) begin
          n_bad++;
          $display("FAIL refill step %0d sum/valid got %0d/%0b want %0d/%0b",
                   k, sum, valid, (k < 4 ? k : 4) * 10, k >= 4);
        end
      end
    end
  endtask

  task automatic test_random();
    int strobes = 0;
    int cyc = 0;
    junk_random = 1;
    do_reset();
    while (strobes < 10000 && cyc < 40000) begin
      bit e = 1'($urandom_range(0, 1));
      drive(e, $urandom_range(0, 255) - 128);
      if (e) strobes++;
      cyc++;
      n_cmp++;
      if (out_en !== exp_out_en || sum !== 10'(exp_sum) || avg !== 8'(exp_avg) || valid !== exp_valid) begin
        n_bad++;
        $display("FAIL random cyc %0d out_en/sum/avg/valid got %0b/%0d/%0d/%0b want %0b/%0d/%0d/%0b",
                 cyc, out_en, sum, avg, valid, exp_out_en, exp_sum, exp_avg, exp_valid);
      end
    end
    n_cmp++;
    if (strobes < 10000) begin
      n_bad++;
      $display("FAIL random strobe budget got %0d want 10000", strobes);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ramp();
    test_min();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
